// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I opcode constants, format enum and decoded-instruction struct
package rv_decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Immediate is kept outside the struct because its width follows XLEN.
  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_we;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// rtl/rv_decode_comb.sv - combinational RV32I decode: format, fields, flags, immediate, illegal check
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output dec_t            o_dec,
  output logic [XLEN-1:0] o_imm
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  fmt_e        w_fmt;
  logic        w_known;
  logic        w_illegal;
  logic        w_use_rd;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic [31:0] w_imm32;

  assign w_op = i_inst[6:0];
  assign w_f3 = i_inst[14:12];
  assign w_f7 = i_inst[31:25];
  assign w_rd = i_inst[11:7];

  always_comb begin
    w_fmt   = FMT_R;
    w_known = 1'b1;
    case (w_op)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: w_fmt = FMT_I;
      OPC_STORE:                                                w_fmt = FMT_S;
      OPC_OP:                                                   w_fmt = FMT_R;
      OPC_BRANCH:                                               w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                                       w_fmt = FMT_U;
      OPC_JAL:                                                  w_fmt = FMT_J;
      default:                                                  w_known = 1'b0;
    endcase
  end

  assign w_illegal = !w_known
                  || (i_inst[1:0] != 2'b11)
                  || ((w_op == OPC_JALR) && (w_f3 != 3'b000))
                  || ((w_op == OPC_OP) && (w_f7 != F7_BASE) && (w_f7 != F7_ALT))
                  || ((w_op == OPC_OP) && (w_f7 == F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101))
                  || ((w_op == OPC_BRANCH) && ((w_f3 == 3'b010) || (w_f3 == 3'b011)));

  assign w_use_rd  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);
  assign w_use_rs1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_use_rs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);

  always_comb begin
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_inst[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Illegal encodings collapse to a NOP carrying only the illegal flag.
  always_comb begin
    o_dec = '0;
    o_imm = '0;
    if (w_illegal) begin
      o_dec.illegal = 1'b1;
    end else begin
      o_dec.op     = w_op;
      o_dec.fmt    = w_fmt;
      o_dec.rd     = w_use_rd  ? w_rd : 5'd0;
      o_dec.rs1    = w_use_rs1 ? i_inst[19:15] : 5'd0;
      o_dec.rs2    = w_use_rs2 ? i_inst[24:20] : 5'd0;
      o_dec.funct3 = ((w_fmt == FMT_U) || (w_fmt == FMT_J)) ? 3'd0 : w_f3;
      o_dec.funct7 = (w_fmt == FMT_R) ? w_f7 : 7'd0;
      o_dec.rs1_en = w_use_rs1;
      o_dec.rs2_en = w_use_rs2;
      o_dec.rd_we  = w_use_rd && (w_rd != 5'd0);
      o_imm        = XLEN'($signed(w_imm32));
    end
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I decode stage with valid/ready, optional skid entry and flush
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_we,
  output logic            out_illegal
);

  dec_t            w_dec;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;
  logic            w_out_free;

  logic            r_out_valid;
  dec_t            r_out_dec;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_imm;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .i_inst (in_inst),
    .o_dec  (w_dec),
    .o_imm  (w_imm)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  if (SKID != 0) begin : g_skid
    logic            r_skid_valid;
    logic            r_in_ready;
    dec_t            r_skid_dec;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_imm;

    // r_in_ready always mirrors !r_skid_valid, so nothing is accepted while the skid is full.
    assign in_ready = r_in_ready && !rst;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
        if (rst) begin
          r_out_dec  <= '0;
          r_out_pc   <= '0;
          r_out_imm  <= '0;
          r_skid_dec <= '0;
          r_skid_pc  <= '0;
          r_skid_imm <= '0;
        end
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_dec    <= r_skid_dec;
          r_out_pc     <= r_skid_pc;
          r_out_imm    <= r_skid_imm;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) begin
            r_out_dec <= w_dec;
            r_out_pc  <= in_pc;
            r_out_imm <= w_imm;
          end
        end
      end else if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_dec   <= w_dec;
        r_skid_pc    <= in_pc;
        r_skid_imm   <= w_imm;
        r_in_ready   <= 1'b0;
      end
    end
  end else begin : g_noskid
    assign in_ready = !rst && w_out_free;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_dec   <= '0;
        r_out_pc    <= '0;
        r_out_imm   <= '0;
      end else if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_out_free) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_dec <= w_dec;
          r_out_pc  <= in_pc;
          r_out_imm <= w_imm;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_op      = r_out_dec.op;
  assign out_rd      = r_out_dec.rd;
  assign out_rs1     = r_out_dec.rs1;
  assign out_rs2     = r_out_dec.rs2;
  assign out_funct3  = r_out_dec.funct3;
  assign out_funct7  = r_out_dec.funct7;
  assign out_fmt     = r_out_dec.fmt;
  assign out_rs1_en  = r_out_dec.rs1_en;
  assign out_rs2_en  = r_out_dec.rs2_en;
  assign out_rd_we   = r_out_dec.rd_we;
  assign out_illegal = r_out_dec.illegal;

endmodule
